// File: rtl/hamming_pkg.sv
// Shared types and constants for the Hamming(7,4) decode arbiter.
package hamming_pkg;

   localparam int CODE_W = 7;
   localparam int MSG_W  = 4;

   // Codeword positions are numbered 1..7 so a syndrome value indexes its bit directly.
   typedef logic [7:1] codeword_t;
   typedef logic [2:0] syndrome_t;

   typedef enum logic {
      EMPTY,
      FULL
   } arb_state_t;

endpackage

// File: rtl/hamming74_correct.sv
// Combinational Hamming(7,4) single-error corrector.
// A nonzero syndrome names the position to flip; double errors miscorrect by design.
module hamming74_correct
   import hamming_pkg::*;
(
   input  codeword_t        code,
   output logic [MSG_W-1:0] data,
   output syndrome_t        syndrome
);

   codeword_t fixed;

   // Compute the parity-check syndrome, flip the named bit and extract the message bits.
   always_comb begin
      syndrome[0] = code[1] ^ code[3] ^ code[5] ^ code[7];
      syndrome[1] = code[2] ^ code[3] ^ code[6] ^ code[7];
      syndrome[2] = code[4] ^ code[5] ^ code[6] ^ code[7];
      fixed = code;
      for (int p = 1; p <= CODE_W; p++) begin
         if (syndrome == syndrome_t'(p)) begin
            fixed[p] = ~code[p];
         end
      end
      data = {fixed[7], fixed[6], fixed[5], fixed[3]};
   end

endmodule

// File: rtl/hamming_decode_arbiter.sv
// Round-robin arbiter sharing one Hamming(7,4) corrector between requesters,
// with a single registered output stage and a saturating corrected-error counter.
module hamming_decode_arbiter
   import hamming_pkg::*;
#(
   parameter  int NUM_REQ = 2,
   parameter  int CNT_W   = 8,
   localparam int SRC_W   = $clog2(NUM_REQ)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*CODE_W-1:0] req_code,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [MSG_W-1:0]          out_data,
   output logic [SRC_W-1:0]          out_src,
   output logic                      out_err,
   output logic [CNT_W-1:0]          err_count,
   input  logic                      clr_count
);

   arb_state_t       state;
   logic [SRC_W-1:0] ptr;
   logic [SRC_W-1:0] grant_idx;
   logic [SRC_W-1:0] ptr_next;
   logic             found;
   logic             can_accept;
   logic             grant;
   codeword_t        granted_code;
   logic [MSG_W-1:0] dec_data;
   syndrome_t        dec_syndrome;
   logic             dec_err;

   // Pick the first valid requester at or after the pointer, wrapping around.
   always_comb begin
      found     = 1'b0;
      grant_idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!found && req_valid[(int'(ptr) + i) % NUM_REQ]) begin
            found     = 1'b1;
            grant_idx = SRC_W'((int'(ptr) + i) % NUM_REQ);
         end
      end
   end

   // Grant only when the output register is free or draining this cycle, and never during reset.
   always_comb begin
      can_accept = (state == EMPTY) || out_ready;
      grant      = found && can_accept && !rst;
      ptr_next   = SRC_W'((int'(grant_idx) + 1) % NUM_REQ);
      req_ready  = '0;
      if (grant) begin
         req_ready[grant_idx] = 1'b1;
      end
   end

   // Route the granted requester's codeword into the shared corrector.
   always_comb begin
      granted_code = req_code[CODE_W*int'(grant_idx) +: CODE_W];
      dec_err      = (dec_syndrome != '0);
   end

   hamming74_correct u_correct (
      .code     (granted_code),
      .data     (dec_data),
      .syndrome (dec_syndrome)
   );

   // Output-stage FSM, round-robin pointer and saturating error counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= EMPTY;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_src   <= '0;
         out_err   <= 1'b0;
         ptr       <= '0;
         err_count <= '0;
      end else begin
         if (grant) begin
            state     <= FULL;
            out_valid <= 1'b1;
            out_data  <= dec_data;
            out_src   <= grant_idx;
            out_err   <= dec_err;
            ptr       <= ptr_next;
         end else if (state == FULL && out_ready) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
         end
         if (clr_count) begin
            err_count <= '0;
         end else if (grant && dec_err && (err_count != {CNT_W{1'b1}})) begin
            err_count <= err_count + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_hamming_decode_arbiter.sv
// Self-checking bench for hamming_decode_arbiter: a behavioural reference model
// checked every cycle, plus directed vectors with hand-computed literal expectations.
module tb_hamming_decode_arbiter;

   localparam int N     = 2;
   localparam int CW    = 2;
   localparam int MAXC  = (1 << CW) - 1;

   logic          clk;
   logic          rst;
   logic [N-1:0]  req_valid;
   logic [13:0]   req_code;
   logic [N-1:0]  req_ready;
   logic          out_valid;
   logic          out_ready;
   logic [3:0]    out_data;
   logic [0:0]    out_src;
   logic          out_err;
   logic [CW-1:0] err_count;
   logic          clr_count;

   int checks_total  = 0;
   int checks_passed = 0;

   // Reference model state
   bit       m_valid;
   bit [3:0] m_data;
   int       m_src;
   bit       m_err;
   int       m_ptr;
   int       m_cnt;

   hamming_decode_arbiter #(.NUM_REQ(N), .CNT_W(CW)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_code  (req_code),
      .req_ready (req_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_src   (out_src),
      .out_err   (out_err),
      .err_count (err_count),
      .clr_count (clr_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks_total++;
      if (got === exp) begin
         checks_passed++;
      end else begin
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // Decode by the textbook rule: syndrome is the XOR of positions holding a 1.
   function automatic void model_decode(input bit [6:0] code, output bit [3:0] data, output bit err);
      int syn = 0;
      bit [6:0] c = code;
      for (int p = 1; p <= 7; p++) begin
         if (c[p-1]) syn = syn ^ p;
      end
      if (syn != 0) c[syn-1] = ~c[syn-1];
      data = {c[6], c[5], c[4], c[2]};
      err  = (syn != 0);
   endfunction

   function automatic int model_grant();
      for (int i = 0; i < N; i++) begin
         if (req_valid[(m_ptr + i) % N]) return (m_ptr + i) % N;
      end
      return -1;
   endfunction

   // Compare on the falling edge, then advance the model on the rising edge.
   initial begin
      int g;
      bit [N-1:0] exp_ready;
      bit [3:0] d;
      bit e;
      forever begin
         @(negedge clk);
         g = model_grant();
         exp_ready = '0;
         if (!rst && g >= 0 && (!m_valid || out_ready)) exp_ready[g] = 1'b1;
         check("req_ready", 32'(req_ready), 32'(exp_ready));
         check("out_valid", 32'(out_valid), 32'(m_valid));
         check("err_count", 32'(err_count), 32'(m_cnt));
         if (m_valid) begin
            check("out_data", 32'(out_data), 32'(m_data));
            check("out_src", 32'(out_src), 32'(m_src));
            check("out_err", 32'(out_err), 32'(m_err));
         end
         @(posedge clk);
         if (rst) begin
            m_valid = 0; m_data = 0; m_src = 0; m_err = 0; m_ptr = 0; m_cnt = 0;
         end else begin
            g = model_grant();
            if (g >= 0 && (!m_valid || out_ready)) begin
               model_decode(req_code[7*g +: 7], d, e);
               m_valid = 1; m_data = d; m_src = g; m_err = e;
               m_ptr = (g + 1) % N;
               if (clr_count) m_cnt = 0;
               else if (e && m_cnt < MAXC) m_cnt = m_cnt + 1;
            end else begin
               if (m_valid && out_ready) m_valid = 0;
               if (clr_count) m_cnt = 0;
            end
         end
      end
   end

   task automatic apply_stimulus(input bit r, input bit [1:0] v, input bit [6:0] c0,
                                 input bit [6:0] c1, input bit ordy, input bit clr);
      @(posedge clk);
      #1;
      rst = r; req_valid = v; req_code = {c1, c0}; out_ready = ordy; clr_count = clr;
   endtask

   task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] exp);
      check(name, got, exp);
   endtask

   localparam bit [6:0] CLEAN  = 7'b1010101;
   localparam bit [6:0] FLIP6  = 7'b1110101;
   localparam bit [6:0] ONEBIT = 7'b0000001;
   localparam bit [6:0] ZERO   = 7'b0000000;

   initial begin
      rst = 1; req_valid = 2'b11; req_code = '0; out_ready = 0; clr_count = 0;
      m_valid = 0; m_data = 0; m_src = 0; m_err = 0; m_ptr = 0; m_cnt = 0;
      apply_stimulus(1, 2'b11, CLEAN, CLEAN, 0, 0);
      @(negedge clk);
      check_output("reset_ready", 32'(req_ready), 32'h0);
      check_output("reset_valid", 32'(out_valid), 32'h0);
      check_output("reset_data", 32'(out_data), 32'h0);
      check_output("reset_count", 32'(err_count), 32'h0);

      // Clean word from requester 0
      apply_stimulus(0, 2'b01, CLEAN, ZERO, 1, 0);
      @(negedge clk);
      check_output("clean_ready", 32'(req_ready), 32'h1);
      apply_stimulus(0, 2'b00, CLEAN, ZERO, 1, 0);
      @(negedge clk);
      check_output("clean_data", 32'(out_data), 32'hB);
      check_output("clean_err", 32'(out_err), 32'h0);
      check_output("clean_src", 32'(out_src), 32'h0);

      // Bit 6 flipped on requester 1
      apply_stimulus(0, 2'b10, CLEAN, FLIP6, 1, 0);
      @(negedge clk);
      check_output("flip6_ready", 32'(req_ready), 32'h2);
      apply_stimulus(0, 2'b00, CLEAN, FLIP6, 1, 0);
      @(negedge clk);
      check_output("flip6_data", 32'(out_data), 32'hB);
      check_output("flip6_err", 32'(out_err), 32'h1);
      check_output("flip6_src", 32'(out_src), 32'h1);
      check_output("flip6_count", 32'(err_count), 32'h1);

      // Single set bit at position 1 corrects to all-zero
      apply_stimulus(0, 2'b01, ONEBIT, ZERO, 1, 0);
      apply_stimulus(0, 2'b00, ONEBIT, ZERO, 1, 0);
      @(negedge clk);
      check_output("pos1_data", 32'(out_data), 32'h0);
      check_output("pos1_err", 32'(out_err), 32'h1);
      check_output("pos1_count", 32'(err_count), 32'h2);

      // Bring the pointer back to 0, then run both requesters continuously
      apply_stimulus(0, 2'b10, CLEAN, CLEAN, 1, 0);
      for (int k = 0; k < 4; k++) begin
         apply_stimulus(0, 2'b11, CLEAN, ZERO, 1, 0);
         @(negedge clk);
         check_output("rr_ready", 32'(req_ready), (k % 2 == 0) ? 32'h1 : 32'h2);
         if (k > 0) check_output("rr_src", 32'(out_src), (k % 2 == 1) ? 32'h0 : 32'h1);
      end

      // Backpressure: drain first, then fill and stall
      apply_stimulus(0, 2'b00, CLEAN, ZERO, 1, 0);
      apply_stimulus(0, 2'b11, CLEAN, ZERO, 0, 0);
      @(negedge clk);
      check_output("bp_fill_ready", 32'(req_ready), 32'h1);
      for (int k = 0; k < 3; k++) begin
         apply_stimulus(0, 2'b11, CLEAN, ZERO, 0, 0);
         @(negedge clk);
         check_output("bp_stall_ready", 32'(req_ready), 32'h0);
         check_output("bp_stall_data", 32'(out_data), 32'hB);
         check_output("bp_stall_src", 32'(out_src), 32'h0);
      end
      apply_stimulus(0, 2'b11, CLEAN, ZERO, 1, 0);
      @(negedge clk);
      check_output("bp_refill_ready", 32'(req_ready), 32'h2);
      apply_stimulus(0, 2'b00, CLEAN, ZERO, 1, 0);
      @(negedge clk);
      check_output("bp_refill_src", 32'(out_src), 32'h1);
      check_output("bp_refill_data", 32'(out_data), 32'h0);

      // Five faulty words saturate the 2-bit counter at 3
      for (int k = 0; k < 5; k++) apply_stimulus(0, 2'b01, ONEBIT, ZERO, 1, 0);
      apply_stimulus(0, 2'b00, ONEBIT, ZERO, 1, 0);
      @(negedge clk);
      check_output("sat_count", 32'(err_count), 32'h3);
      apply_stimulus(0, 2'b01, ONEBIT, ZERO, 1, 1);
      apply_stimulus(0, 2'b00, ONEBIT, ZERO, 1, 0);
      @(negedge clk);
      check_output("clr_count", 32'(err_count), 32'h0);

      // Reset while holding a stalled result
      apply_stimulus(0, 2'b01, ONEBIT, ZERO, 0, 0);
      apply_stimulus(0, 2'b00, ONEBIT, ZERO, 0, 0);
      @(negedge clk);
      check_output("pre_rst_valid", 32'(out_valid), 32'h1);
      apply_stimulus(1, 2'b11, CLEAN, CLEAN, 0, 0);
      @(negedge clk);
      check_output("in_rst_ready", 32'(req_ready), 32'h0);
      apply_stimulus(0, 2'b11, CLEAN, ZERO, 0, 0);
      @(negedge clk);
      check_output("post_rst_valid", 32'(out_valid), 32'h0);
      check_output("post_rst_count", 32'(err_count), 32'h0);
      check_output("post_rst_ready", 32'(req_ready), 32'h1);
      apply_stimulus(0, 2'b00, CLEAN, ZERO, 1, 0);
      @(negedge clk);
      check_output("post_rst_src", 32'(out_src), 32'h0);

      apply_stimulus(0, 2'b00, CLEAN, ZERO, 1, 0);
      apply_stimulus(0, 2'b00, CLEAN, ZERO, 1, 0);
      @(negedge clk);
      #1;
      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule

// File: doc/hamming_decode_arbiter.md
Name: hamming_decode_arbiter

Overview:
- Shares one Hamming(7,4) single-error-correcting decode datapath between NUM_REQ requesters.
- Round-robin arbitration; one registered output stage with valid/ready handshake; tags each result with its source index and a corrected-error flag.
- Maintains a saturating corrected-error counter for fault-injection experiments.
- Sits between fault-injection/encoder sources and the display/consumer logic.

Parameters:
- NUM_REQ, 2, number of requesters (≥2).
- CNT_W, 8, width of err_count.
- SRC_W, $clog2(NUM_REQ), width of out_src (derived, not overridden).

Ports:
- clk  in  1  clock, all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  requester i has a codeword.
- req_code  in  NUM_REQ*7  codeword i at bits [7*i+6 : 7*i]. Slice bit 0 is codeword position 1; slice bit 6 is position 7.
- req_ready  out  NUM_REQ  one-hot or zero; grant/accept for requester i.
- out_valid  out  1  result held in output register.
- out_ready  in  1  consumer accepts result.
- out_data  out  4  decoded message, {c7,c6,c5,c3} after correction.
- out_src  out  SRC_W  index of requester that supplied the word.
- out_err  out  1  syndrome was nonzero, so one bit was corrected.
- err_count  out  CNT_W  saturating count of accepted words with out_err=1.
- clr_count  in  1  synchronous clear of err_count.

Behaviour:
- Reset (rst=1 at a clock edge):
  - out_valid=0, out_data=0, out_src=0, out_err=0, err_count=0.
  - Round-robin pointer = 0, so requester 0 has highest priority first.
  - Reset mid-transfer discards the held result. req_ready must be 0 while rst=1.
- State machine, 2 states:
  - EMPTY: out_valid=0. Transitions to FULL on a grant.
  - FULL: out_valid=1. Returns to EMPTY on out_ready with no new grant; stays FULL on out_ready plus a grant.
- Accept condition: can_accept = (state==EMPTY) | out_ready.
  - The output register may refill in the same cycle it drains.
  - Full throughput is 1 word/cycle.
- Arbitration (combinational):
  - Among req_valid bits, grant the first set bit at or after the pointer, wrapping modulo NUM_REQ.
  - req_ready[g]=1 only if can_accept and a valid exists. All other req_ready bits are 0.
  - req_ready must not depend on req_code.
- On a grant, the pointer becomes (g+1) mod NUM_REQ. With no grant, the pointer holds.
- Decode (combinational on the granted word, registered at the edge):
  - Syndrome = XOR of indices 1..7 of set codeword bits (3 bits).
  - Nonzero syndrome s flips position s.
  - out_data = {c7,c6,c5,c3} of the corrected word. out_err = (s≠0). out_src = g.
- Double errors are not detected. They miscorrect and are flagged out_err=1; this is by design.
- Latency: a word granted at edge N appears with out_valid=1 after edge N, i.e. one cycle.
- Output stability: while out_valid=1 and out_ready=0, out_data, out_src and out_err are held.
- err_count:
  - Increments at the grant edge when out_err of the new word is 1.
  - Saturates at 2^CNT_W−1.
  - If clr_count and an increment coincide, clr_count wins and the result is 0.
- A requester deasserting req_valid without a grant is legal; no state changes.

Decomposition:
- Package hamming_pkg:
  - CODE_W=7 and MSG_W=4 localparams.
  - typedef logic [7:1] codeword_t.
  - typedef logic [2:0] syndrome_t.
  - typedef enum {EMPTY, FULL} arb_state_t.
- Sub-module hamming74_correct: purely combinational.
  - Input codeword_t; outputs data[3:0] and syndrome_t.
  - Instantiated once on the muxed granted codeword.
- Arbiter, pointer, output register, FSM and counter live in the top module.

Test Plan:
- Reset, then req_valid=01, req_code[0]=7'b1010101 (data 1011, clean), out_ready=1:
  - req_ready=01; next cycle out_valid=1, out_data=4'b1011, out_err=0, out_src=0, err_count=0.
- Single-bit fault:
  - req_code[1]=7'b1110101 (bit 6 flipped), only req_valid[1]: out_data=4'b1011, out_err=1, out_src=1, err_count=1.
  - req_code=7'b0000001: out_data=0000, out_err=1.
- Round-robin fairness:
  - Both req_valid=1 continuously, out_ready=1, pointer=0.
  - Grants alternate 0,1,0,1; out_src sequence 0,1,0,1; one result per cycle.
- Backpressure:
  - out_ready=0 for 3 cycles with both requesters valid: req_ready=00 after the first fill; out_* stable.
  - Raising out_ready drains and refills in the same cycle.
- Counter saturation and clear:
  - CNT_W=2, five faulty words: err_count stops at 3.
  - clr_count asserted together with a faulty accept: err_count=0.
- Reset mid-operation:
  - Assert rst while out_valid=1 and out_ready=0: next cycle out_valid=0, err_count=0, req_ready=00 during reset.
  - After release, requester 0 is granted first when both are valid.
